rr_onehot_arbiter: RTL and testbench

- Registered round-robin arbiter for up to N requesters. It produces the one-hot grant vector that feeds onehot_to_binary / one_hot_mux_2d select inputs in spcom datapaths.
- Holds each grant until the owner signals completion with `done`. An optional timeout forces release of a hung owner.
- Guarantees a strictly one-hot or all-zero grant, so downstream one-hot checkers never fire.

---
 rtl/rr_onehot_arbiter_pkg.sv | 30 +++
 rtl/rr_onehot_arbiter_if.sv | 13 +
 rtl/rr_onehot_arbiter_ffs.sv | 10 +
 rtl/rr_onehot_arbiter.sv | 92 +++++++++
 tb/tb_rr_onehot_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared spcom helpers for the round-robin arbiter: log2, FSM encoding and
// the thermometer pointer-mask builder.
package rr_onehot_arbiter_pkg;

  localparam int MAX_N = 64;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_GRANT = 1'b1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Thermometer mask with every bit at or above ptr set.
  function automatic logic [MAX_N-1:0] therm_from(input int ptr);
    logic [MAX_N-1:0] m;
    for (int i = 0; i < MAX_N; i++) m[i] = (i >= ptr);
    return m;
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_onehot_arbiter_if #(
  parameter int N = 16
);
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic         timeout;

  modport master (output req, done, input gnt, gnt_vld, timeout);
  modport slave  (input req, done, output gnt, gnt_vld, timeout);
endinterface

// File: rtl/rr_onehot_arbiter_ffs.sv
// Lowest-set-bit isolator: returns a one-hot (or zero) copy of the input.
module ffs_onehot #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] onehot
);
  // Two's complement trick keeps only the least significant one.
  assign onehot = vec & (~vec + WIDTH'(1));
endmodule

// File: rtl/rr_onehot_arbiter.sv
// Registered round-robin arbiter with hold-until-done grants and an optional
// hold timeout that force-releases a hung owner.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int N       = 16,
  parameter int TIMEOUT = 0
) (
  input logic                clk,
  input logic                rst,
  rr_onehot_arbiter_if.slave bus
);

  localparam int CNT_WIDTH = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [N-1:0] PTR_RST = N'(therm_from(0));

  logic [0:0]           state;
  logic [N-1:0]         gnt_q;
  logic                 gnt_vld_q;
  logic                 timeout_q;
  logic [N-1:0]         ptr_mask;
  logic [CNT_WIDTH-1:0] hold_cnt;

  logic [N-1:0] above, rel_mask, arb_mask, hi, sel_hi, sel_req, sel;
  logic         force_rel, release_ev;

  // Mask strictly above the current owner; wraps to all-ones past bit N-1.
  assign above    = ~(gnt_q | (gnt_q - N'(1)));
  assign rel_mask = (above == '0) ? '1 : above;

  // While granted, a release re-arbitrates against the post-release mask.
  assign arb_mask = (state == ARB_GRANT) ? rel_mask : ptr_mask;
  assign hi       = bus.req & arb_mask;

  ffs_onehot #(.WIDTH(N)) u_ffs_hi  (.vec(hi),      .onehot(sel_hi));
  ffs_onehot #(.WIDTH(N)) u_ffs_req (.vec(bus.req), .onehot(sel_req));

  assign sel = (|hi) ? sel_hi : sel_req;

  if (TIMEOUT != 0) begin : g_to
    assign force_rel = (hold_cnt == CNT_WIDTH'(TIMEOUT - 1)) && !bus.done;
  end else begin : g_no_to
    assign force_rel = 1'b0;
  end

  assign release_ev = (state == ARB_GRANT) && (bus.done || force_rel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
      ptr_mask  <= PTR_RST;
      hold_cnt  <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|bus.req) begin
            gnt_q     <= sel;
            gnt_vld_q <= 1'b1;
            state     <= ARB_GRANT;
            hold_cnt  <= '0;
          end
        end
        ARB_GRANT: begin
          if (release_ev) begin
            ptr_mask  <= rel_mask;
            timeout_q <= force_rel;
            hold_cnt  <= '0;
            if (|bus.req) begin
              gnt_q <= sel;
            end else begin
              gnt_q     <= '0;
              gnt_vld_q <= 1'b0;
              state     <= ARB_IDLE;
            end
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter (N=4, TIMEOUT=8): directed sequences with literal
// expectations plus randomized traffic compared against a round-robin model.
module tb_rr_onehot_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_onehot_arbiter_if #(.N(N)) bus ();

  rr_onehot_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference: owner index (-1 idle), next-priority index, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit forced;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (bus.req != '0) begin
        m_owner = pick(bus.req, m_ptr);
        m_hold  = 0;
      end
    end else begin
      forced = (m_hold == TO - 1) && !bus.done;
      m_to   = forced;
      if (bus.done || forced) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = (bus.req != '0) ? pick(bus.req, m_ptr) : -1;
        m_hold  = 0;
      end else begin
        m_hold++;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] eg;
    if (chk_en) begin
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      check("model_gnt", 32'(bus.gnt), 32'(eg));
      check("model_gnt_vld", 32'(bus.gnt_vld), 32'(m_owner >= 0));
      check("model_timeout", 32'(bus.timeout), 32'(m_to));
      check("onehot", 32'($countones(bus.gnt) <= 1), 32'(1));
      check("vld_eq_or", 32'(bus.gnt_vld), 32'(|bus.gnt));
    end
  end

  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic d);
    rst      = r;
    bus.req  = rq;
    bus.done = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt [N];
    logic [N-1:0] fair_exp [4];
    logic [N-1:0] alt_exp [3];
    int done_div;

    fair_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    alt_exp  = '{4'b0100, 4'b0001, 4'b0100};
    rst = 1'b1; bus.req = '0; bus.done = 1'b0;

    // Reset and first grant
    cyc(1'b1, 4'b0101, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 4'b0101, 1'b0);
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);
    cyc(1'b0, 4'b0101, 1'b0);
    check("first_gnt", 32'(bus.gnt), 32'h1);
    check("first_vld", 32'(bus.gnt_vld), 32'h1);

    // Back-to-back alternation, no idle bubble
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b0101, 1'b1);
      check("alt_gnt", 32'(bus.gnt), 32'(alt_exp[i]));
    end

    // Reset in the middle of a grant with done asserted
    cyc(1'b1, 4'b0101, 1'b1);
    check("midrst_gnt", 32'(bus.gnt), 32'h0);
    check("midrst_timeout", 32'(bus.timeout), 32'h0);
    cyc(1'b0, 4'b1111, 1'b0);
    check("postrst_gnt", 32'(bus.gnt), 32'h1);

    // Fairness with all requesting
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 4'b1111, 1'b1);
      for (int b = 0; b < N; b++) if (bus.gnt[b]) cnt[b]++;
      if (i < 4) check("fair_seq", 32'(bus.gnt), 32'(fair_exp[i]));
    end
    for (int b = 0; b < N; b++) check("fair_count", 32'(cnt[b]), 32'd4);

    // Timeout on a hung owner, then re-grant
    cyc(1'b0, 4'b0010, 1'b1);
    check("to_start", 32'(bus.gnt), 32'h2);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 4'b0010, 1'b0);
      check("to_hold_gnt", 32'(bus.gnt), 32'h2);
      check("to_hold_pulse", 32'(bus.timeout), 32'h0);
    end
    cyc(1'b0, 4'b0010, 1'b0);
    check("to_regrant", 32'(bus.gnt), 32'h2);
    check("to_pulse", 32'(bus.timeout), 32'h1);
    cyc(1'b0, 4'b0010, 1'b0);
    check("to_pulse_end", 32'(bus.timeout), 32'h0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b0010, 1'b0);
    cyc(1'b0, 4'b0010, 1'b1);
    check("done_at_limit_to", 32'(bus.timeout), 32'h0);
    check("done_at_limit_gnt", 32'(bus.gnt), 32'h2);

    // Release to idle, done while idle, owner dropping req
    cyc(1'b0, 4'b0000, 1'b1);
    check("idle_gnt", 32'(bus.gnt), 32'h0);
    check("idle_vld", 32'(bus.gnt_vld), 32'h0);
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    check("idle_done_gnt", 32'(bus.gnt), 32'h0);
    cyc(1'b0, 4'b0001, 1'b0);
    check("drop_start", 32'(bus.gnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b0000, 1'b0);
      check("drop_hold", 32'(bus.gnt), 32'h1);
    end
    cyc(1'b0, 4'b0000, 1'b1);
    check("drop_release_gnt", 32'(bus.gnt), 32'h0);
    check("drop_release_vld", 32'(bus.gnt_vld), 32'h0);

    // Random traffic; some stretches rarely assert done to reach the timeout
    done_div = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) done_div = ($urandom_range(0, 1) == 1) ? 2 : 20;
      cyc($urandom_range(0, 199) == 0, N'($urandom()),
          $urandom_range(0, done_div - 1) == 0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
